// File: rtl/add_accum_pkg.sv
// add_accum_pkg: mode encodings and default sizing for the multi-channel accumulator.
package add_accum_pkg;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT = 1'b1;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CHANNELS = 4;
endpackage

// File: rtl/add_accum_lane.sv
// add_accum_lane: single-channel accumulator with sticky overflow.
// Saturation is built only when ADD_ACCUM_SAT_EN is defined; otherwise the lane always wraps.
module add_accum_lane
  import add_accum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             add_en,
  input  logic             clr,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] acc,
  output logic             ovf
);
  logic [WIDTH-1:0] acc_q, acc_d;
  logic ovf_q, ovf_d;
  logic [WIDTH:0] sum;
`ifndef ADD_ACCUM_SAT_EN
  logic sat_mode_unused;
  assign sat_mode_unused = sat_mode;
`endif
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, data};
`ifdef ADD_ACCUM_SAT_EN
    acc_d = clr ? '0 : !add_en ? acc_q : (sum[WIDTH] && sat_mode == MODE_SAT) ? '1 : sum[WIDTH-1:0];
`else
    acc_d = clr ? '0 : add_en ? sum[WIDTH-1:0] : acc_q;
`endif
    ovf_d = clr ? 1'b0 : ovf_q | (add_en & sum[WIDTH]);
  end
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  assign acc = acc_q;
  assign ovf = ovf_q;
endmodule

// File: rtl/add_accum_multi.sv
// add_accum_multi: CHANNELS independent accumulators with select decode and a done pulse.
// Define ADD_ACCUM_SAT_EN to build saturate mode; without it the sat input is ignored.
module add_accum_multi
  import add_accum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_b,
  input  logic [WIDTH-1:0]          data,
  input  logic [CH_W-1:0]           ch_sel,
  input  logic                      enable,
  input  logic                      clear,
  input  logic                      sat,
  output logic [CHANNELS*WIDTH-1:0] accum,
  output logic [CHANNELS-1:0]       overflow,
  output logic                      done,
  output logic [CH_W-1:0]           done_ch
);
  logic valid, accept;
  logic done_q, done_d;
  logic [CH_W-1:0] done_ch_q, done_ch_d;
  always_comb begin
    valid = 32'(ch_sel) < CHANNELS;
    accept = valid & (enable | clear);
    done_d = accept;
    done_ch_d = accept ? ch_sel : done_ch_q;
  end
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic hit;
    assign hit = valid && ch_sel == CH_W'(k);
    add_accum_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .reset_b (reset_b),
      .add_en  (hit & enable & ~clear),
      .clr     (hit & clear),
      .sat_mode(sat),
      .data    (data),
      .acc     (accum[k*WIDTH +: WIDTH]),
      .ovf     (overflow[k])
    );
  end
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      done_q <= 1'b0;
      done_ch_q <= '0;
    end else begin
      done_q <= done_d;
      done_ch_q <= done_ch_d;
    end
  assign done = done_q;
  assign done_ch = done_ch_q;
endmodule

// File: tb/tb_add_accum_multi.sv
// tb_add_accum_multi: random and directed checks of a 4-channel and a 3-channel build against an integer model.
module tb_add_accum_multi;
`ifdef ADD_ACCUM_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_b = 1'b0;
  logic [3:0] data = '0;
  logic [1:0] ch_sel = '0;
  logic enable = 1'b0, clear = 1'b0, sat = 1'b0;
  logic [15:0] accum4;
  logic [3:0] ovf4;
  logic done4;
  logic [1:0] dch4;
  logic [11:0] accum3;
  logic [2:0] ovf3;
  logic done3;
  logic [1:0] dch3;
  int tests = 0, fails = 0;
  int m_acc[2][4];
  bit m_ovf[2][4];
  bit m_done[2];
  int m_dch[2];
  always #5 clk = ~clk;
  add_accum_multi #(.WIDTH(4), .CHANNELS(4)) dut4 (
    .clk(clk), .reset_b(reset_b), .data(data), .ch_sel(ch_sel), .enable(enable),
    .clear(clear), .sat(sat), .accum(accum4), .overflow(ovf4), .done(done4), .done_ch(dch4));
  add_accum_multi #(.WIDTH(4), .CHANNELS(3)) dut3 (
    .clk(clk), .reset_b(reset_b), .data(data), .ch_sel(ch_sel), .enable(enable),
    .clear(clear), .sat(sat), .accum(accum3), .overflow(ovf3), .done(done3), .done_ch(dch3));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 4; k++) begin
        m_acc[n][k] = 0;
        m_ovf[n][k] = 0;
      end
      m_done[n] = 0;
      m_dch[n] = 0;
    end
  endtask
  task automatic model_update(input int c, input int d, input bit e, input bit cl, input bit s);
    for (int n = 0; n < 2; n++) begin
      int chans = (n == 0) ? 4 : 3;
      m_done[n] = (c < chans) && (e || cl);
      if (c < chans) begin
        m_dch[n] = c;
        if (cl) begin
          m_acc[n][c] = 0;
          m_ovf[n][c] = 0;
        end else if (e) begin
          int total = m_acc[n][c] + d;
          if (total > 15) begin
            m_ovf[n][c] = 1;
            m_acc[n][c] = (s && SAT_EN) ? 15 : total - 16;
          end else m_acc[n][c] = total;
        end
      end
    end
  endtask
  task automatic check_all(input string tag);
    logic [15:0] ea4, ea3;
    logic [3:0] eo4, eo3;
    ea4 = '0; ea3 = '0; eo4 = '0; eo3 = '0;
    for (int k = 0; k < 4; k++) begin
      ea4 = ea4 | (16'(m_acc[0][k]) << (4 * k));
      eo4[k] = m_ovf[0][k];
    end
    for (int k = 0; k < 3; k++) begin
      ea3 = ea3 | (16'(m_acc[1][k]) << (4 * k));
      eo3[k] = m_ovf[1][k];
    end
    chk({tag, ".acc4"}, 32'(accum4), 32'(ea4));
    chk({tag, ".ovf4"}, 32'(ovf4), 32'(eo4));
    chk({tag, ".done4"}, 32'(done4), 32'(m_done[0]));
    if (m_done[0]) chk({tag, ".dch4"}, 32'(dch4), 32'(m_dch[0]));
    chk({tag, ".acc3"}, 32'(accum3), 32'(ea3[11:0]));
    chk({tag, ".ovf3"}, 32'(ovf3), 32'(eo3[2:0]));
    chk({tag, ".done3"}, 32'(done3), 32'(m_done[1]));
    if (m_done[1]) chk({tag, ".dch3"}, 32'(dch3), 32'(m_dch[1]));
  endtask
  task automatic step(input string tag, input int c, input int d, input bit e, input bit cl, input bit s);
    ch_sel = 2'(c); data = 4'(d); enable = e; clear = cl; sat = s;
    @(posedge clk); #1;
    model_update(c, d, e, cl, s);
    check_all(tag);
  endtask
  task automatic reset_pulse(input string tag);
    #2 reset_b = 1'b0;
    #1;
    model_reset();
    chk({tag, ".acc4"}, 32'(accum4), 0);
    chk({tag, ".ovf4"}, 32'(ovf4), 0);
    chk({tag, ".done4"}, 32'(done4), 0);
    chk({tag, ".acc3"}, 32'(accum3), 0);
    @(posedge clk); #1;
    reset_b = 1'b1;
  endtask
  initial begin
    model_reset();
    #1;
    chk("por.acc4", 32'(accum4), 0);
    chk("por.ovf4", 32'(ovf4), 0);
    chk("por.done4", 32'(done4), 0);
    chk("por.dch4", 32'(dch4), 0);
    @(posedge clk); #1;
    reset_b = 1'b1;
    for (int i = 0; i < 4; i++) step("wrap5", 0, 5, 1, 0, 0);
    chk("wrap5.final", 32'(accum4[3:0]), 4);
    chk("wrap5.ovf", 32'(ovf4[0]), 1);
    step("sticky", 0, 1, 1, 0, 0);
    chk("sticky.acc", 32'(accum4[3:0]), 5);
    chk("sticky.ovf", 32'(ovf4[0]), 1);
    step("sat9a", 1, 9, 1, 0, 1);
    chk("sat9a.acc", 32'(accum4[7:4]), 9);
    step("sat9b", 1, 9, 1, 0, 1);
    chk("sat9b.acc", 32'(accum4[7:4]), SAT_EN ? 15 : 2);
    step("sat9c", 1, 9, 1, 0, 1);
    step("ch2a", 2, 14, 1, 0, 0);
    step("ch2b", 2, 9, 1, 0, 0);
    chk("ch2b.acc", 32'(accum4[11:8]), 7);
    chk("ch2b.ovf", 32'(ovf4[2]), 1);
    step("clrpri", 2, 3, 1, 1, 0);
    chk("clrpri.acc", 32'(accum4[11:8]), 0);
    chk("clrpri.ovf", 32'(ovf4[2]), 0);
    chk("clrpri.done", 32'(done4), 1);
    chk("clrpri.dch", 32'(dch4), 2);
    step("ch3inv", 3, 9, 1, 0, 1);
    chk("ch3inv.done3", 32'(done3), 0);
    step("ch3b", 3, 9, 1, 0, 1);
    chk("ch3b.acc4", 32'(accum4[15:12]), SAT_EN ? 15 : 2);
    chk("ch3b.ovf4", 32'(ovf4[3]), 1);
    step("idle", 1, 7, 0, 0, 0);
    chk("idle.done", 32'(done4), 0);
    ch_sel = 2'd0; data = 4'd6; enable = 1'b1; clear = 1'b0;
    reset_pulse("arst");
    step("postrst", 0, 6, 1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_pulse("arst2");
      step("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
